axi4_wr_burst_scheduler: RTL and testbench
==========================================

Name: axi4_wr_burst_scheduler

Overview:
Sequences AXI4 write bursts for one long write transfer. It accepts a transfer request (start address, total beat count, max burst length) and splits it into burst descriptors {id, addr, len}, which feed the write-address/aux generator. Bursts never cross a 4 KB boundary. The block limits outstanding bursts by counting B responses, then reports completion and error status for the transfer.

Parameters:
ASIZE, 32, address width.
LSIZE, 8, descriptor len width (len = beats-1).
IDSIZE, 4, descriptor id width.
BYTES_PER_BEAT, 8, bytes per data beat; power of 2, ≤4096.
MAX_OUTSTANDING, 4, max bursts issued without B response (1..15).

Ports:
clock  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  transfer request valid
req_ready  out  1  scheduler can accept a request
req_addr  in  ASIZE  start byte address, BYTES_PER_BEAT aligned
req_beats  in  32  total beats in transfer
req_max_len  in  LSIZE+1  max beats per burst; 0 treated as 1; values above 2**LSIZE clamped to 2**LSIZE
desc_valid  out  1  descriptor valid
desc_ready  in  1  descriptor accepted
desc_id  out  IDSIZE  burst id
desc_addr  out  ASIZE  burst start byte address
desc_len  out  LSIZE  burst beats-1
b_valid  in  1  B channel beat
b_ready  out  1  constant 1
b_resp  in  2  B response code
outstanding  out  4  bursts issued minus responses received
busy  out  1  not IDLE
done  out  1  one-cycle pulse at transfer end
err  out  1  sticky per transfer, cleared at next request accept

Behaviour:
- Reset (rst high at clock edge): state IDLE; req_ready=1; desc_valid=0; desc_id=0; desc_addr=0; desc_len=0; outstanding=0; busy=0; done=0; err=0. Reset mid-transfer abandons it immediately with no done pulse. The id counter restarts at 0.
- FSM states: IDLE, CALC, ISSUE, WAIT_RESP.
- IDLE: req_ready=1. On req_valid&&req_ready:
  - latch addr, remaining=req_beats, and the clamped max_len;
  - clear err.
  - If req_beats==0: done=1 next cycle, stay IDLE.
  - Else go to CALC.
- CALC (1 cycle minimum), req_ready=0:
  - room = (4096 - addr[11:0]) / BYTES_PER_BEAT;
  - burst = min(remaining, max_len, room), computed at 33-bit width, result ≥1.
  - Go to ISSUE only if outstanding < MAX_OUTSTANDING (counting a same-cycle decrement as already applied); otherwise hold in CALC.
- ISSUE: desc_valid=1; desc_id/addr/len are registered and stable until desc_ready. On handshake:
  - addr += burst*BYTES_PER_BEAT;
  - remaining -= burst;
  - id += 1 (wraps mod 2**IDSIZE, persists across transfers);
  - outstanding += 1.
  - Then go to WAIT_RESP if remaining==0, else CALC.
- Latency: request accepted at cycle N gives the first desc_valid at N+2. Back-to-back bursts issue every 2 cycles at most.
- WAIT_RESP: when outstanding==0, pulse done for 1 cycle and return to IDLE. req_ready rises in the same cycle as done.
- B handling, in any state:
  - b_valid with outstanding>0 decrements outstanding.
  - b_resp != 0 sets err.
  - b_valid with outstanding==0 is ignored but sets err.
  - Issue handshake and b_valid in the same cycle leave outstanding unchanged.
- Address wrap past 2**ASIZE is modulo; no error.
- busy=1 in CALC, ISSUE and WAIT_RESP.

Test Plan:
1. Single burst: addr=0x1000, beats=16, max_len=64, BPB=8 → one descriptor {id0, 0x1000, len 15}; one B okay → done pulse, err=0.
2. Length split: addr=0, beats=300, max_len=128 → descriptors len 127, 127, 43 at addrs 0x000, 0x400, 0x800; ids 0, 1, 2.
3. 4 KB split: addr=0x0FC0, beats=32, max_len=256, BPB=8 → len 7 @0x0FC0, then len 23 @0x1000.
4. Outstanding limit: MAX_OUTSTANDING=2, beats=64, max_len=8, B withheld → exactly 2 descriptors issued, then stall in CALC. Releasing one B → third descriptor within 2 cycles. Also hold desc_ready low for 5 cycles and check the fields stay stable.
5. Errors/edge cases: one B with b_resp=2 → err=1 at done. A stray b_valid in IDLE → err=1. beats=0 → done one cycle after accept, no descriptor.
6. Reset while 3 bursts are outstanding → all outputs return to reset values next cycle, no done. A new request then issues id 0.

Source files
------------

// File: rtl/axi4_wr_burst_scheduler.sv
// Splits one long AXI4 write transfer into {id, addr, len} burst descriptors that
// never cross a 4 KB page, throttled by the number of bursts awaiting a B response.
module axi4_wr_burst_scheduler #(
  parameter int ASIZE           = 32,
  parameter int LSIZE           = 8,
  parameter int IDSIZE          = 4,
  parameter int BYTES_PER_BEAT  = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ASIZE-1:0]  req_addr,
  input  logic [31:0]       req_beats,
  input  logic [LSIZE:0]    req_max_len,
  output logic              desc_valid,
  input  logic              desc_ready,
  output logic [IDSIZE-1:0] desc_id,
  output logic [ASIZE-1:0]  desc_addr,
  output logic [LSIZE-1:0]  desc_len,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [1:0]        b_resp,
  output logic [3:0]        outstanding,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int LW         = LSIZE + 1;
  localparam int BEAT_SHIFT = $clog2(BYTES_PER_BEAT);
  localparam logic [LW-1:0] MAX_LEN_CAP = {1'b1, {LSIZE{1'b0}}};
  localparam logic [3:0]    MAX_OUT     = 4'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ISSUE, S_WAIT_RESP} state_t;

  state_t            r_state, w_next_state;
  logic [ASIZE-1:0]  r_addr;
  logic [31:0]       r_remaining;
  logic [LW-1:0]     r_max_len;
  logic [LW-1:0]     r_burst;
  logic [IDSIZE-1:0] r_id;
  logic [ASIZE-1:0]  r_desc_addr;
  logic [LSIZE-1:0]  r_desc_len;
  logic [3:0]        r_outstanding;
  logic              r_done;
  logic              r_err;

  logic              w_accept, w_issue, w_b_dec, w_can_issue;
  logic [3:0]        w_out_after_b;
  logic [LW-1:0]     w_max_len, w_burst;
  logic [12:0]       w_room;
  logic [32:0]       w_rem_x, w_max_x, w_room_x;
  logic [ASIZE-1:0]  w_step;

  assign w_accept      = req_valid && (r_state == S_IDLE);
  assign w_issue       = (r_state == S_ISSUE) && desc_ready;
  assign w_b_dec       = b_valid && (r_outstanding != 4'd0);
  // A response landing this cycle already frees its slot for the issue decision.
  assign w_out_after_b = r_outstanding - {3'b000, w_b_dec};
  assign w_can_issue   = w_out_after_b < MAX_OUT;
  assign w_step        = ASIZE'(r_burst) << BEAT_SHIFT;

  // Beats left before the next 4 KB page boundary.
  assign w_room   = (13'd4096 - {1'b0, r_addr[11:0]}) >> BEAT_SHIFT;
  assign w_rem_x  = {1'b0, r_remaining};
  assign w_max_x  = 33'(r_max_len);
  assign w_room_x = 33'(w_room);

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    w_max_len = req_max_len;
    if (req_max_len == '0)              w_max_len = LW'(1);
    else if (req_max_len > MAX_LEN_CAP) w_max_len = MAX_LEN_CAP;
  end

  always_comb begin
    w_burst = r_max_len;
    if (w_rem_x <= w_max_x && w_rem_x <= w_room_x) w_burst = LW'(r_remaining);
    else if (w_room_x < w_max_x)                   w_burst = LW'(w_room);
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      if (w_accept && req_beats != 32'd0) w_next_state = S_CALC;
      S_CALC:      if (w_can_issue) w_next_state = S_ISSUE;
      S_ISSUE:     if (w_issue) w_next_state = (r_remaining == 32'(r_burst)) ? S_WAIT_RESP : S_CALC;
      S_WAIT_RESP: if (r_outstanding == 4'd0) w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_remaining   <= '0;
      r_max_len     <= '0;
      r_burst       <= '0;
      r_id          <= '0;
      r_desc_addr   <= '0;
      r_desc_len    <= '0;
      r_outstanding <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= (w_accept && req_beats == 32'd0) ||
                 (r_state == S_WAIT_RESP && r_outstanding == 4'd0);

      if (w_accept) begin
        r_addr      <= req_addr;
        r_remaining <= req_beats;
        r_max_len   <= w_max_len;
      end

      if (r_state == S_CALC && w_can_issue) begin
        r_desc_addr <= r_addr;
        r_desc_len  <= LSIZE'(w_burst - 1'b1);
        r_burst     <= w_burst;
      end

      if (w_issue) begin
        r_addr      <= r_addr + w_step;
        r_remaining <= r_remaining - 32'(r_burst);
        r_id        <= r_id + 1'b1;
      end

      case ({w_issue, w_b_dec})
        2'b10:   r_outstanding <= r_outstanding + 4'd1;
        2'b01:   r_outstanding <= r_outstanding - 4'd1;
        default: r_outstanding <= r_outstanding;
      endcase

      // A response error in the accept cycle still counts against the new transfer.
      if (w_accept) r_err <= 1'b0;
      if (b_valid && (b_resp != 2'b00 || r_outstanding == 4'd0)) r_err <= 1'b1;
    end
  end

  assign req_ready   = (r_state == S_IDLE);
  assign desc_valid  = (r_state == S_ISSUE);
  assign desc_id     = r_id;
  assign desc_addr   = r_desc_addr;
  assign desc_len    = r_desc_len;
  assign b_ready     = 1'b1;
  assign outstanding = r_outstanding;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign err         = r_err;

endmodule

// File: tb/tb_axi4_wr_burst_scheduler.sv
// Directed bench for axi4_wr_burst_scheduler: table of transfers with hand-computed
// descriptors, plus sequences for throttling, errors, zero-length and reset.
module tb_axi4_wr_burst_scheduler;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  // Shared request fields
  logic [31:0] req_addr    = '0;
  logic [31:0] req_beats   = '0;
  logic [8:0]  req_max_len = '0;
  logic [1:0]  b_resp      = '0;

  // Main instance (MAX_OUTSTANDING = 4)
  logic        req_valid = 1'b0, desc_ready = 1'b0, b_valid = 1'b0;
  logic        req_ready, desc_valid, b_ready, busy, done, err;
  logic [3:0]  desc_id, outstanding;
  logic [31:0] desc_addr;
  logic [7:0]  desc_len;

  // Throttle instance (MAX_OUTSTANDING = 2)
  logic        req_valid_2 = 1'b0, desc_ready_2 = 1'b0, b_valid_2 = 1'b0;
  logic        req_ready_2, desc_valid_2, b_ready_2, busy_2, done_2, err_2;
  logic [3:0]  desc_id_2, outstanding_2;
  logic [31:0] desc_addr_2;
  logic [7:0]  desc_len_2;

  axi4_wr_burst_scheduler #(.MAX_OUTSTANDING(4)) dut (
    .clock(clock), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_beats(req_beats), .req_max_len(req_max_len),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_id(desc_id),
    .desc_addr(desc_addr), .desc_len(desc_len),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
    .outstanding(outstanding), .busy(busy), .done(done), .err(err)
  );

  axi4_wr_burst_scheduler #(.MAX_OUTSTANDING(2)) dut2 (
    .clock(clock), .rst(rst),
    .req_valid(req_valid_2), .req_ready(req_ready_2), .req_addr(req_addr),
    .req_beats(req_beats), .req_max_len(req_max_len),
    .desc_valid(desc_valid_2), .desc_ready(desc_ready_2), .desc_id(desc_id_2),
    .desc_addr(desc_addr_2), .desc_len(desc_len_2),
    .b_valid(b_valid_2), .b_ready(b_ready_2), .b_resp(b_resp),
    .outstanding(outstanding_2), .busy(busy_2), .done(done_2), .err(err_2)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] beats;
    logic [8:0]  max_len;
    int          n_desc;
  } xfer_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } desc_t;

  xfer_t xv[6];
  desc_t dv[12];

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_id = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic start_req(input logic [31:0] a, input logic [31:0] b, input logic [8:0] m);
    check("req_ready before accept", req_ready, 1'b1);
    req_addr    = a;
    req_beats   = b;
    req_max_len = m;
    req_valid   = 1'b1;
    tick();
    req_valid   = 1'b0;
  endtask

  task automatic wait_desc(output int cyc);
    cyc = 0;
    while (!desc_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check("desc_valid arrives", desc_valid, 1'b1);
  endtask

  task automatic take_desc(input logic [1:0] resp);
    desc_ready = 1'b1;
    tick();
    desc_ready = 1'b0;
    exp_id     = exp_id + 4'd1;
    b_valid    = 1'b1;
    b_resp     = resp;
    tick();
    b_valid    = 1'b0;
    b_resp     = 2'b00;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 60) begin
      tick();
      n++;
    end
    check("done pulse", done, 1'b1);
    check("req_ready with done", req_ready, 1'b1);
    tick();
    check("done one cycle only", done, 1'b0);
  endtask

  task automatic check_reset_state();
    check("rst req_ready", req_ready, 1'b1);
    check("rst desc_valid", desc_valid, 1'b0);
    check("rst desc_id", desc_id, 4'd0);
    check("rst desc_addr", desc_addr, 32'd0);
    check("rst desc_len", desc_len, 8'd0);
    check("rst outstanding", outstanding, 4'd0);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst err", err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int di, cyc, cnt;
    logic done_seen;

    xv[0] = '{32'h0000_1000, 32'd16,  9'd64,  1};
    xv[1] = '{32'h0000_0000, 32'd300, 9'd128, 3};
    xv[2] = '{32'h0000_0FC0, 32'd32,  9'd256, 2};
    xv[3] = '{32'h0000_2000, 32'd2,   9'd0,   2};
    xv[4] = '{32'h0000_3000, 32'd300, 9'd511, 2};
    xv[5] = '{32'hFFFF_FFF0, 32'd4,   9'd16,  2};

    dv[0]  = '{32'h0000_1000, 8'd15};
    dv[1]  = '{32'h0000_0000, 8'd127};
    dv[2]  = '{32'h0000_0400, 8'd127};
    dv[3]  = '{32'h0000_0800, 8'd43};
    dv[4]  = '{32'h0000_0FC0, 8'd7};
    dv[5]  = '{32'h0000_1000, 8'd23};
    dv[6]  = '{32'h0000_2000, 8'd0};
    dv[7]  = '{32'h0000_2008, 8'd0};
    dv[8]  = '{32'h0000_3000, 8'd255};
    dv[9]  = '{32'h0000_3800, 8'd43};
    dv[10] = '{32'hFFFF_FFF0, 8'd1};
    dv[11] = '{32'h0000_0000, 8'd1};

    rst = 1'b1;
    tick();
    tick();
    check_reset_state();
    rst = 1'b0;
    tick();

    // Table-driven transfers, one B okay per burst
    di = 0;
    for (int i = 0; i < 6; i++) begin
      start_req(xv[i].addr, xv[i].beats, xv[i].max_len);
      check("busy after accept", busy, 1'b1);
      for (int k = 0; k < xv[i].n_desc; k++) begin
        wait_desc(cyc);
        if (i == 0 && k == 0) check("first desc latency", cyc, 1);
        check($sformatf("x%0d d%0d id", i, k), desc_id, exp_id);
        check($sformatf("x%0d d%0d addr", i, k), desc_addr, dv[di].addr);
        check($sformatf("x%0d d%0d len", i, k), desc_len, dv[di].len);
        take_desc(2'b00);
        di++;
      end
      wait_done();
      check($sformatf("x%0d err", i), err, 1'b0);
      check($sformatf("x%0d outstanding", i), outstanding, 4'd0);
    end

    // SLVERR response sets err
    start_req(32'h0000_5000, 32'd8, 9'd8);
    wait_desc(cyc);
    check("slverr desc len", desc_len, 8'd7);
    take_desc(2'b10);
    wait_done();
    check("slverr err", err, 1'b1);

    // Zero-beat transfer: done next cycle, err cleared at accept, no descriptor
    start_req(32'h0000_7000, 32'd0, 9'd4);
    check("zero done", done, 1'b1);
    check("zero err cleared", err, 1'b0);
    check("zero no desc", desc_valid, 1'b0);
    check("zero not busy", busy, 1'b0);
    tick();
    check("zero done pulse", done, 1'b0);
    check("zero still no desc", desc_valid, 1'b0);

    // Stray B in IDLE
    b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    check("stray b err", err, 1'b1);
    check("stray b outstanding", outstanding, 4'd0);

    // Throttling on the MAX_OUTSTANDING=2 instance
    req_addr     = 32'h0;
    req_beats    = 32'd64;
    req_max_len  = 9'd8;
    req_valid_2  = 1'b1;
    tick();
    req_valid_2  = 1'b0;
    desc_ready_2 = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (desc_valid_2 && desc_ready_2) cnt++;
      tick();
    end
    desc_ready_2 = 1'b0;
    check("throttle issued", cnt, 2);
    check("throttle outstanding", outstanding_2, 4'd2);
    check("throttle stalled", desc_valid_2, 1'b0);
    check("throttle busy", busy_2, 1'b1);
    b_valid_2 = 1'b1;
    tick();
    b_valid_2 = 1'b0;
    cyc = 0;
    while (!desc_valid_2 && cyc < 2) begin
      tick();
      cyc++;
    end
    check("throttle resume", desc_valid_2, 1'b1);
    check("throttle outstanding after b", outstanding_2, 4'd1);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("hold c%0d valid", c), desc_valid_2, 1'b1);
      check($sformatf("hold c%0d id", c), desc_id_2, 4'd2);
      check($sformatf("hold c%0d addr", c), desc_addr_2, 32'h80);
      check($sformatf("hold c%0d len", c), desc_len_2, 8'd7);
      tick();
    end

    // Reset with three bursts outstanding
    start_req(32'h0000_6000, 32'd24, 9'd8);
    desc_ready = 1'b1;
    cyc = 0;
    while (outstanding != 4'd3 && cyc < 40) begin
      tick();
      cyc++;
    end
    desc_ready = 1'b0;
    check("pre-reset outstanding", outstanding, 4'd3);
    check("pre-reset busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    check_reset_state();
    rst = 1'b0;
    done_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (done) done_seen = 1'b1;
      tick();
    end
    check("no done after reset", done_seen, 1'b0);
    exp_id = 4'd0;
    start_req(32'h0000_8000, 32'd8, 9'd8);
    wait_desc(cyc);
    check("post-reset id", desc_id, exp_id);
    check("post-reset addr", desc_addr, 32'h8000);
    check("post-reset len", desc_len, 8'd7);
    take_desc(2'b00);
    wait_done();
    check("post-reset err", err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
